// File: rtl/x9_pkg.sv
// Shared X9 definitions: word/PC widths and the program-loader state encoding.
package x9_pkg;

  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned PC_W      = 12;
  localparam int unsigned RUN_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prog_loader.sv
// X9 program loader: streams host words into instruction memory, then runs the core.
// Define PROG_LOADER_CHECKSUM_EN to add the exp_sum port and an XOR check before RUN.
module prog_loader
  import x9_pkg::*;
#(
  parameter int unsigned D  = PC_W,
  parameter int unsigned W  = INSTR_W,
  parameter int unsigned CW = RUN_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          imem_wr_en,
  output logic [D-1:0]  imem_wr_addr,
  output logic [W-1:0]  imem_wr_data,
  output logic          core_run,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic          err,
  output logic [D:0]    prog_len,
  output logic [CW-1:0] run_cycles
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  input  logic [W-1:0]  exp_sum
`endif
);

  localparam int unsigned LEN_W = D + 1;

  loader_state_t    state_q, state_d;
  logic [D-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_en_q, wr_en_d;
  logic [D-1:0]     wr_addr_q, wr_addr_d;
  logic [W-1:0]     wr_data_q, wr_data_d;
  logic             run_done_q, run_done_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             core_run_q, core_run_d;
  logic             busy_q, busy_d;
  logic             cnt_clr_c, cnt_en_c;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [W-1:0]     sum_q, sum_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    run_done_d = run_done_q;
    err_d      = err_q;
    cnt_clr_c  = 1'b0;
    cnt_en_c   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (load_req) begin
          state_d    = ST_LOAD;
          ptr_d      = '0;
          len_d      = '0;
          run_done_d = 1'b0;
          err_d      = 1'b0;
          cnt_clr_c  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          ptr_d     = ptr_q + D'(1);
          len_d     = len_q + LEN_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = sum_q ^ in_data;
`endif
          if (in_last) begin
            state_d = ST_DRAIN;
          end else if (ptr_q == {D{1'b1}}) begin
            // Last address written without in_last: program does not fit
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (sum_q == exp_sum) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        cnt_en_c = 1'b1;
        if (core_done) begin
          state_d    = ST_HALT;
          run_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs registered from the next state so they track state_q exactly
    in_ready_d = (state_d == ST_LOAD);
    core_run_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_DRAIN) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      run_done_q <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      core_run_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      run_done_q <= run_done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      core_run_q <= core_run_d;
      busy_q     <= busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  sat_counter #(.WIDTH(CW)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_c),
    .en    (cnt_en_c),
    .count (run_cycles)
  );

  assign in_ready     = in_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign core_run     = core_run_q;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign err          = err_q;
  assign prog_len     = len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed table, random programs vs. a list model,
// and a small-geometry instance (D=4, CW=8) for overflow and counter saturation.
module tb_prog_loader;

  localparam int unsigned D   = 12;
  localparam int unsigned W   = 9;
  localparam int unsigned CW  = 16;
  localparam int unsigned SD  = 4;
  localparam int unsigned SCW = 8;

  logic          clk, reset;
  logic          load_req, in_valid, in_last, core_done;
  logic [W-1:0]  in_data, exp_sum;
  logic          in_ready, imem_wr_en, core_run, busy, run_done, err;
  logic [D-1:0]  imem_wr_addr;
  logic [W-1:0]  imem_wr_data;
  logic [D:0]    prog_len;
  logic [CW-1:0] run_cycles;

  logic           s_load_req, s_in_valid, s_in_last, s_core_done;
  logic [W-1:0]   s_in_data, s_exp_sum;
  logic           s_in_ready, s_imem_wr_en, s_core_run, s_busy, s_run_done, s_err;
  logic [SD-1:0]  s_imem_wr_addr;
  logic [W-1:0]   s_imem_wr_data;
  logic [SD:0]    s_prog_len;
  logic [SCW-1:0] s_run_cycles;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [D-1:0]  wa_q[$];
  logic [W-1:0]  wd_q[$];
  logic [SD-1:0] s_wa_q[$];
  bit            s_run_seen;

  prog_loader #(.D(D), .W(W), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .core_run(core_run), .core_done(core_done), .busy(busy), .run_done(run_done),
    .err(err), .prog_len(prog_len), .run_cycles(run_cycles)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum)
`endif
  );

  prog_loader #(.D(SD), .W(W), .CW(SCW)) u_small (
    .clk(clk), .reset(reset), .load_req(s_load_req), .in_valid(s_in_valid),
    .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready),
    .imem_wr_en(s_imem_wr_en), .imem_wr_addr(s_imem_wr_addr), .imem_wr_data(s_imem_wr_data),
    .core_run(s_core_run), .core_done(s_core_done), .busy(s_busy), .run_done(s_run_done),
    .err(s_err), .prog_len(s_prog_len), .run_cycles(s_run_cycles)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .exp_sum(s_exp_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      wa_q.push_back(imem_wr_addr);
      wd_q.push_back(imem_wr_data);
    end
    if (s_imem_wr_en === 1'b1) s_wa_q.push_back(s_imem_wr_addr);
    if (s_core_run === 1'b1) s_run_seen = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned sat_model(input int unsigned cycles, input int unsigned width);
    int unsigned lim;
    lim = (32'd1 << width) - 1;
    return (cycles > lim) ? lim : cycles;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Streams words as beats; leaves the DUT in its DRAIN cycle after the last beat.
  task automatic send_beats(input string tag, input logic [W-1:0] words[$],
                            input logic [3:0] vpat, input bit rnd);
    int unsigned i, cyc;
    bit v;
    i = 0;
    cyc = 0;
    while (i < words.size()) begin
      v = rnd ? ($urandom_range(0, 2) != 0) : vpat[cyc % 4];
      in_valid = v;
      in_data  = v ? words[i] : W'($urandom);
      in_last  = v && (i == words.size() - 1);
      if (rnd) begin
        load_req  = ($urandom_range(0, 3) == 0);
        core_done = ($urandom_range(0, 1) == 1);
      end
      tick();
      if (v) i++;
      cyc++;
      if (cyc > 1000) begin
        check({tag, "/beat_budget"}, 32'(i), 32'(words.size()));
        break;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    load_req  = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [W-1:0] words[$]);
    check({tag, "/n_writes"}, 32'(wa_q.size()), 32'(words.size()));
    for (int k = 0; k < words.size() && k < wa_q.size(); k++) begin
      check($sformatf("%s/addr%0d", tag, k), 32'(wa_q[k]), 32'(k));
      check($sformatf("%s/data%0d", tag, k), 32'(wd_q[k]), 32'(words[k]));
    end
  endtask

  // Full load-and-run; expected values come from the caller's table or model.
  task automatic run_program(input string tag, input logic [W-1:0] words[$],
                             input logic [3:0] vpat, input bit rnd, input int unsigned run_len,
                             input int unsigned exp_len, input int unsigned exp_cyc);
    logic [W-1:0] xs;
    xs = '0;
    foreach (words[k]) xs ^= words[k];
    exp_sum = xs;
    wa_q.delete();
    wd_q.delete();
    pulse_load();
    check({tag, "/in_ready_load"}, 32'(in_ready), 32'd1);
    send_beats(tag, words, vpat, rnd);
    check({tag, "/drain_run"}, 32'(core_run), 32'd0);
    check({tag, "/drain_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "/run_rise"}, 32'(core_run), 32'd1);
    for (int unsigned k = 1; k <= run_len; k++) begin
      core_done = (k == run_len);
      if (rnd && k < run_len) load_req = ($urandom_range(0, 3) == 0);
      tick();
    end
    core_done = 1'b0;
    load_req  = 1'b0;
    check({tag, "/halt_run"}, 32'(core_run), 32'd0);
    check({tag, "/run_done"}, 32'(run_done), 32'd1);
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/err"}, 32'(err), 32'd0);
    check({tag, "/prog_len"}, 32'(prog_len), 32'(exp_len));
    check({tag, "/run_cycles"}, 32'(run_cycles), 32'(exp_cyc));
    check_writes(tag, words);
  endtask

  task automatic s_load(input int unsigned n, input bit last_at_end);
    logic [W-1:0] xs;
    xs = '0;
    for (int unsigned i = 0; i < n; i++) xs ^= W'(i * 7 + 3);
    s_exp_sum  = xs;
    s_wa_q.delete();
    s_load_req = 1'b1;
    tick();
    s_load_req = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = W'(i * 7 + 3);
      s_in_last  = last_at_end && (i == n - 1);
      tick();
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
  endtask

  typedef struct {
    int unsigned n;
    logic [W-1:0] w [4];
    logic [3:0]   vpat;
    int unsigned  run_len;
    int unsigned  exp_len;
    int unsigned  exp_cyc;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [W-1:0] words[$];
    int unsigned n, rl;

    vecs[0] = '{3, '{9'h1A3, 9'h0F0, 9'h155, 9'h000}, 4'b1111, 5, 3, 5};
    vecs[1] = '{4, '{9'h011, 9'h1FF, 9'h080, 9'h0AA}, 4'b0101, 2, 4, 2};
    vecs[2] = '{1, '{9'h0C3, 9'h000, 9'h000, 9'h000}, 4'b1111, 1, 1, 1};
    vecs[3] = '{2, '{9'h100, 9'h001, 9'h000, 9'h000}, 4'b0011, 7, 2, 7};

    reset = 1'b0;
    {load_req, in_valid, in_last, core_done} = '0;
    in_data = '0;
    exp_sum = '0;
    {s_load_req, s_in_valid, s_in_last, s_core_done} = '0;
    s_in_data = '0;
    s_exp_sum = '0;
    s_run_seen = 1'b0;
    tick();
    tick();
    check("rst/in_ready", 32'(in_ready), 32'd0);
    check("rst/wr_en", 32'(imem_wr_en), 32'd0);
    check("rst/wr_addr", 32'(imem_wr_addr), 32'd0);
    check("rst/wr_data", 32'(imem_wr_data), 32'd0);
    check("rst/core_run", 32'(core_run), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/run_done", 32'(run_done), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    check("rst/prog_len", 32'(prog_len), 32'd0);
    check("rst/run_cycles", 32'(run_cycles), 32'd0);
    reset = 1'b1;
    tick();

    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("idle_done_ignored", 32'(run_done), 32'd0);

    for (int v = 0; v < 4; v++) begin
      words.delete();
      for (int unsigned k = 0; k < vecs[v].n; k++) words.push_back(vecs[v].w[k]);
      run_program($sformatf("vec%0d", v), words, vecs[v].vpat, 1'b0,
                  vecs[v].run_len, vecs[v].exp_len, vecs[v].exp_cyc);
    end

    for (int r = 0; r < 8; r++) begin
      words.delete();
      n  = $urandom_range(1, 12);
      rl = $urandom_range(1, 40);
      for (int unsigned k = 0; k < n; k++) words.push_back(W'($urandom));
      run_program($sformatf("rnd%0d", r), words, 4'b1111, 1'b1, rl, n, sat_model(rl, CW));
    end

    // Reset dropped while running a 2-word program
    words.delete();
    words.push_back(9'h055);
    words.push_back(9'h0AA);
    exp_sum = 9'h055 ^ 9'h0AA;
    pulse_load();
    send_beats("rst_run", words, 4'b1111, 1'b0);
    tick();
    tick();
    tick();
    check("rst_run/pre_run", 32'(core_run), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_run/core_run", 32'(core_run), 32'd0);
    check("rst_run/busy", 32'(busy), 32'd0);
    check("rst_run/prog_len", 32'(prog_len), 32'd0);
    check("rst_run/run_cycles", 32'(run_cycles), 32'd0);
    check("rst_run/wr_addr", 32'(imem_wr_addr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    words.delete();
    words.push_back(9'h1E1);
    words.push_back(9'h00F);
    words.push_back(9'h123);
    run_program("reload", words, 4'b1111, 1'b0, 4, 3, 4);

`ifdef PROG_LOADER_CHECKSUM_EN
    words.delete();
    words.push_back(9'h001);
    words.push_back(9'h002);
    run_program("csum_ok", words, 4'b1111, 1'b0, 2, 2, 2);
    exp_sum = 9'h000;
    pulse_load();
    send_beats("csum_bad", words, 4'b1111, 1'b0);
    tick();
    check("csum_bad/err", 32'(err), 32'd1);
    check("csum_bad/core_run", 32'(core_run), 32'd0);
    tick();
    tick();
    check("csum_bad/held", 32'(core_run), 32'd0);
`endif

    // Overflow on the 16-entry instance
    s_run_seen = 1'b0;
    s_load(16, 1'b0);
    check("ovf/err", 32'(s_err), 32'd1);
    check("ovf/in_ready", 32'(s_in_ready), 32'd0);
    check("ovf/prog_len", 32'(s_prog_len), 32'd16);
    tick();
    tick();
    check("ovf/n_writes", 32'(s_wa_q.size()), 32'd16);
    for (int k = 0; k < s_wa_q.size(); k++)
      check($sformatf("ovf/addr%0d", k), 32'(s_wa_q[k]), 32'(k));
    check("ovf/run_seen", 32'(s_run_seen), 32'd0);

    // Full-depth program ending exactly on the last address is legal
    s_load(16, 1'b1);
    check("full/err", 32'(s_err), 32'd0);
    check("full/prog_len", 32'(s_prog_len), 32'd16);
    tick();
    check("full/run", 32'(s_core_run), 32'd1);

    // Saturation: hold core_done low well past 2^SCW-1 cycles
    for (int k = 0; k < 300; k++) tick();
    check("sat/run_cycles", 32'(s_run_cycles), 32'(sat_model(301, SCW)));
    check("sat/still_run", 32'(s_core_run), 32'd1);
    s_core_done = 1'b1;
    tick();
    s_core_done = 1'b0;
    check("sat/run_done", 32'(s_run_done), 32'd1);
    check("sat/final_cycles", 32'(s_run_cycles), 32'd255);
    check("sat/halt", 32'(s_core_run), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
